irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
Request-capture and service-handshake stage wrapped around the 4-to-2 priority encoder.
- Upstream role: latches four raw request lines into a sticky pending register, applies a mask, and drives the encoder's 4-bit input.
- Downstream role: takes the encoder's index and valid outputs back, presents one request at a time to a consumer via a valid/ack handshake, and clears the serviced pending bit.
- Encoder priority: I[3] highest, I[0] lowest.

Parameters:
EDGE_MODE, 1, 1 = capture rising edges of req; 0 = capture level (pending set every cycle req bit is high)
GAP_CYCLES, 1, idle cycles after ack before the next request is presented; legal range 1..3

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req  input  4  raw request lines, already synchronous to clk
mask  input  4  1 = bit excluded from encoder input; pending still records it
enc_i  output  4  to encoder I input; equals pending & ~mask, combinational
enc_y  input  2  from encoder y output
enc_v  input  1  from encoder v output
irq_valid  output  1  registered; a request index is being presented
irq_id  output  2  registered; index of the presented request
irq_ack  input  1  consumer accepts the presented request
pending  output  4  registered sticky pending register

Behaviour:
- Reset: when rst_n is low at a clk edge, the following all go to 0: pending, req_d (previous-req register), irq_valid, irq_id, gap counter. FSM goes to IDLE. Reset takes effect mid-handshake as well; any in-flight request is lost.
- Capture:
  - EDGE_MODE=1: rise = req & ~req_d.
  - EDGE_MODE=0: rise = req.
  - pending_next = (pending & ~clr) | rise.
  - Set wins over clear on the same bit in the same cycle.
- FSM states: IDLE, PRESENT, GAP.
- IDLE:
  - If enc_v=1: irq_id <= enc_y, irq_valid <= 1, go to PRESENT.
  - Otherwise stay in IDLE.
  - Latency: a lone unmasked rise at edge N sets pending at edge N; irq_valid goes high at edge N+1.
- PRESENT:
  - irq_valid and irq_id are held stable regardless of new higher-priority requests or mask changes. No preemption.
  - When irq_ack=1: clr = one-hot(irq_id), irq_valid <= 0, load the gap counter with GAP_CYCLES, go to GAP.
  - The pending bit clears at the same edge that irq_valid drops.
- GAP:
  - Decrement the counter each cycle; go to IDLE when it reaches 0.
  - Purpose: the encoder sees the updated pending before the next sample.
  - irq_valid stays 0 throughout.
- irq_ack outside PRESENT is ignored (no clear, no state change).
- A pending bit whose mask is set stays pending. It is presented only after unmasking, subject to priority.
- Repeated rises on an already-pending bit are not counted (single sticky bit).
- enc_v=0 with enc_y nonzero is ignored.
- Back-to-back throughput: with GAP_CYCLES=1, one request per 3 cycles when the consumer acks immediately.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, PRESENT=2'd1, GAP=2'd2) and the request-vector width constant 4.
- One natural sub-module: irq_edge_capture. It holds req_d, the rise logic (EDGE_MODE) and the pending register with set-wins-clear semantics.
- FSM and handshake stay in the top module.
- The encoder is instantiated by the parent, not inside this block, so the bench can pair this block with the real encoder or a model.

Test Plan:
All scenarios use the real 4-to-2 priority encoder, EDGE_MODE=1, GAP_CYCLES=1, mask=0 unless stated.
1. Reset: hold rst_n=0 with req=4'b1111 -> pending=0, irq_valid=0, irq_id=0. Release reset with req still 4'b1111 -> no rise captured, pending stays 0.
2. Single request: req 0000->0100 at edge N -> pending=0100 at N, irq_valid=1 and irq_id=2 at N+1. Ack at N+2 -> pending=0000 and irq_valid=0 at N+2; state returns to IDLE at N+3.
3. Priority ordering: rises on bits 0 and 3 at the same edge -> irq_id=3 first. Ack -> after the gap, irq_id=0 is presented. Ack -> pending=0000.
4. No preemption and mask:
   - While irq_id=1 is presented, bit 3 rises -> irq_id holds at 1 until ack; irq_id=3 is presented afterwards.
   - Separately, with mask=4'b1000 and bit 3 pending -> irq_valid stays 0. Set mask=0 -> irq_id=3 is presented.
5. Set-wins-clear: in PRESENT with irq_id=2, irq_ack=1 and a fresh rise on req[2] (req[2] pulsed low beforehand) in the same cycle -> pending[2] stays 1, and irq_id=2 is presented again after the gap.
6. Reset mid-operation and stray ack:
   - irq_ack=1 in IDLE -> no change.
   - rst_n=0 for one edge while in PRESENT -> irq_valid=0, pending=0, state IDLE on the next cycle.

Source files
------------

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and FSM encoding for the interrupt pending/handshake stage.
package irq_pending_ctrl_pkg;

    localparam int REQ_W = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } state_e;

    // One-hot mask selecting the pending bit for a request index.
    function automatic logic [REQ_W-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [REQ_W-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Request, encoder-loop and consumer handshake signals of irq_pending_ctrl.
interface irq_pending_ctrl_if;
    import irq_pending_ctrl_pkg::*;

    logic [REQ_W-1:0] req;
    logic [REQ_W-1:0] mask;
    logic [REQ_W-1:0] enc_i;
    logic [ID_W-1:0]  enc_y;
    logic             enc_v;
    logic             irq_valid;
    logic [ID_W-1:0]  irq_id;
    logic             irq_ack;
    logic [REQ_W-1:0] pending;

    // The block itself.
    modport slave (
        input  req, mask, enc_y, enc_v, irq_ack,
        output enc_i, irq_valid, irq_id, pending
    );

    // Surroundings: request sources, encoder and consumer.
    modport master (
        output req, mask, enc_y, enc_v, irq_ack,
        input  enc_i, irq_valid, irq_id, pending
    );

endinterface

// File: rtl/irq_edge_capture.sv
// Request capture: previous-req register, rise detection and the sticky
// pending register where a new rise beats a same-cycle clear.
module irq_edge_capture
    import irq_pending_ctrl_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_W-1:0] req_i,
    input  logic [REQ_W-1:0] clr_i,
    output logic [REQ_W-1:0] pending_o
);

    logic [REQ_W-1:0] req_d_q;
    logic [REQ_W-1:0] pending_q;
    logic [REQ_W-1:0] pending_d;
    logic [REQ_W-1:0] rise;
    logic             armed_q;

    // Rise detection. req_d clears in reset, so the first edge after release
    // is used only to learn the current req level: lines already high when
    // reset lifts are not treated as new edges.
    always_comb begin
        rise = '0;
        if (EDGE_MODE != 0) begin
            if (armed_q) rise = req_i & ~req_d_q;
        end else begin
            rise = req_i;
        end
        pending_d = (pending_q & ~clr_i) | rise;
    end

    // Capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_d_q   <= '0;
            pending_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            req_d_q   <= req_i;
            pending_q <= pending_d;
            armed_q   <= 1'b1;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Pending-request capture feeding an external 4-to-2 priority encoder, and a
// non-preemptive valid/ack presentation of the encoder's choice.
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter int EDGE_MODE  = 1,
    parameter int GAP_CYCLES = 1   // legal 1..3
) (
    input  logic               clk,
    input  logic               rst_n,
    irq_pending_ctrl_if.slave  bus
);

    localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES);

    state_e           state_q, state_d;
    logic             irq_valid_q, irq_valid_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [1:0]       gap_q, gap_d;
    logic [REQ_W-1:0] clr;
    logic [REQ_W-1:0] pending;

    irq_edge_capture #(
        .EDGE_MODE (EDGE_MODE)
    ) u_capture (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (bus.req),
        .clr_i     (clr),
        .pending_o (pending)
    );

    assign bus.enc_i     = pending & ~bus.mask;
    assign bus.pending   = pending;
    assign bus.irq_valid = irq_valid_q;
    assign bus.irq_id    = irq_id_q;

    // Handshake FSM: sample encoder in IDLE, hold in PRESENT until ack,
    // then let the cleared pending settle through the encoder during GAP.
    always_comb begin
        state_d     = state_q;
        irq_valid_d = irq_valid_q;
        irq_id_d    = irq_id_q;
        gap_d       = gap_q;
        clr         = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enc_v) begin
                    irq_id_d    = bus.enc_y;
                    irq_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (bus.irq_ack) begin
                    clr         = id_onehot(irq_id_q);
                    irq_valid_d = 1'b0;
                    gap_d       = GAP_LOAD;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 2'd1;
                if (gap_q <= 2'd1) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                irq_valid_d = 1'b0;
                gap_d       = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // FSM and presentation registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            gap_q       <= gap_d;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl with a behavioural priority encoder and a
// request-level reference model (sticky pending set, presentation, hold-off).
module tb_irq_pending_ctrl;

    localparam int GAP = 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    irq_pending_ctrl_if bus_if ();

    irq_pending_ctrl #(
        .EDGE_MODE  (1),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    // 4-to-2 priority encoder, I[3] highest.
    always_comb begin
        bus_if.enc_v = |bus_if.enc_i;
        bus_if.enc_y = 2'd0;
        for (int i = 0; i < 4; i++)
            if (bus_if.enc_i[i]) bus_if.enc_y = 2'(i);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [3:0] m_pend;
    logic [3:0] m_prev;
    logic       m_armed;
    logic       m_busy;
    logic [1:0] m_id;
    int         m_hold;

    function automatic logic [1:0] top_bit(input logic [3:0] v);
        logic [1:0] h;
        h = 2'd0;
        for (int i = 0; i < 4; i++)
            if (v[i]) h = 2'(i);
        return h;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        logic [3:0] rise;
        logic [3:0] elig;
        logic [3:0] np;
        if (!rst_n) begin
            m_pend = '0; m_prev = '0; m_armed = 1'b0;
            m_busy = 1'b0; m_id = '0; m_hold = 0;
        end else begin
            rise = m_armed ? (bus_if.req & ~m_prev) : 4'd0;
            elig = m_pend & ~bus_if.mask;
            np   = m_pend;
            if (m_busy) begin
                if (bus_if.irq_ack) begin
                    np[m_id] = 1'b0;
                    m_busy   = 1'b0;
                    m_hold   = GAP;
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (elig != 4'd0) begin
                m_busy = 1'b1;
                m_id   = top_bit(elig);
            end
            m_pend  = np | rise;
            m_prev  = bus_if.req;
            m_armed = 1'b1;
        end
    endtask

    // One cycle: check the combinational encoder feed, clock, check state.
    task automatic tick();
        #1;
        chk("enc_i", bus_if.enc_i, m_pend & ~bus_if.mask);
        model_edge();
        @(posedge clk);
        #1;
        chk("pending", bus_if.pending, m_pend);
        chk("irq_valid", {3'b0, bus_if.irq_valid}, {3'b0, m_busy});
        if (m_busy) chk("irq_id", {2'b0, bus_if.irq_id}, {2'b0, m_id});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        m_pend = '0; m_prev = '0; m_armed = 1'b0;
        m_busy = 1'b0; m_id = '0; m_hold = 0;
        rst_n = 1'b0;
        bus_if.req = 4'b1111; bus_if.mask = 4'b0000; bus_if.irq_ack = 1'b0;
        @(posedge clk); #1;

        // 1. reset with all requests high, then release with them still high
        ticks(2);
        chk("rst_pending", bus_if.pending, 4'b0000);
        chk("rst_id", {2'b0, bus_if.irq_id}, 4'd0);
        rst_n = 1'b1;
        ticks(2);
        chk("rel_no_rise", bus_if.pending, 4'b0000);

        // 2. single request
        bus_if.req = 4'b0000; tick();
        bus_if.req = 4'b0100; tick();
        chk("t2_pend", bus_if.pending, 4'b0100);
        tick();
        chk("t2_id", {2'b0, bus_if.irq_id}, 4'd2);
        bus_if.irq_ack = 1'b1; tick();
        chk("t2_clr", bus_if.pending, 4'b0000);
        bus_if.irq_ack = 1'b0; ticks(2);

        // 3. priority ordering
        bus_if.req = 4'b0000; tick();
        bus_if.req = 4'b1001; ticks(2);
        chk("t3_first", {2'b0, bus_if.irq_id}, 4'd3);
        bus_if.irq_ack = 1'b1; tick();
        bus_if.irq_ack = 1'b0; ticks(2);
        chk("t3_second", {2'b0, bus_if.irq_id}, 4'd0);
        bus_if.irq_ack = 1'b1; tick();
        bus_if.irq_ack = 1'b0; ticks(2);
        chk("t3_empty", bus_if.pending, 4'b0000);

        // 4a. no preemption
        bus_if.req = 4'b0000; tick();
        bus_if.req = 4'b0010; ticks(2);
        bus_if.req = 4'b1010; ticks(3);
        chk("t4_hold", {2'b0, bus_if.irq_id}, 4'd1);
        bus_if.irq_ack = 1'b1; tick();
        bus_if.irq_ack = 1'b0; ticks(2);
        chk("t4_next", {2'b0, bus_if.irq_id}, 4'd3);
        bus_if.irq_ack = 1'b1; tick();
        bus_if.irq_ack = 1'b0; ticks(2);

        // 4b. masked pending bit waits for unmask
        bus_if.req = 4'b0000; bus_if.mask = 4'b1000; tick();
        bus_if.req = 4'b1000; ticks(3);
        chk("t4_masked", {3'b0, bus_if.irq_valid}, 4'd0);
        bus_if.mask = 4'b0000; tick();
        chk("t4_unmask", {2'b0, bus_if.irq_id}, 4'd3);
        bus_if.irq_ack = 1'b1; tick();
        bus_if.irq_ack = 1'b0; ticks(2);

        // 5. set wins over clear
        bus_if.req = 4'b0000; tick();
        bus_if.req = 4'b0100; ticks(2);
        bus_if.req = 4'b0000; tick();
        bus_if.req = 4'b0100; bus_if.irq_ack = 1'b1; tick();
        chk("t5_setwins", bus_if.pending, 4'b0100);
        bus_if.irq_ack = 1'b0; ticks(2);
        chk("t5_again", {2'b0, bus_if.irq_id}, 4'd2);
        bus_if.irq_ack = 1'b1; tick();
        bus_if.irq_ack = 1'b0; ticks(2);

        // 6. stray ack in IDLE, then reset during PRESENT
        bus_if.req = 4'b0000; bus_if.irq_ack = 1'b1; ticks(2);
        bus_if.irq_ack = 1'b0;
        bus_if.req = 4'b0001; ticks(2);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk("t6_valid", {3'b0, bus_if.irq_valid}, 4'd0);
        chk("t6_pend", bus_if.pending, 4'b0000);
        ticks(2);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            bus_if.req     = 4'($urandom);
            bus_if.mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            bus_if.irq_ack = 1'($urandom_range(0, 1));
            rst_n          = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
